// File: rtl/binary_one_hot_pkg.sv
// Shared types, mode constants and the per-bit decode function for the binary_one_hot stream decoder.
// Thermometer decode is compiled in only when BIN_OH_THERMO_EN is defined.
package binary_one_hot_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam logic MODE_ONE_HOT = 1'b0;
  localparam logic MODE_THERMO  = 1'b1;

  // Value of output bit idx for a code bin decoded into a width-bit word.
  // Out-of-range codes decode to all zeros in either mode.
  function automatic logic decode_bit(input logic [31:0] bin,
                                      input logic [31:0] idx,
                                      input logic [31:0] width,
                                      input logic        mode);
    if (bin >= width) return 1'b0;
    return (mode == MODE_THERMO) ? (idx <= bin) : (idx == bin);
  endfunction

endpackage

// File: rtl/binary_one_hot_dec.sv
// Purely combinational decode of a binary code into a one-hot or thermometer word plus an out-of-range flag.
module binary_one_hot_dec
  import binary_one_hot_pkg::*;
#(
  parameter int BINARY  = 4,
  parameter int ONE_HOT = 16
) (
  input  logic [BINARY-1:0]  i_bin,
  input  logic               i_mode,
  output logic [ONE_HOT-1:0] o_word,
  output logic               o_err
);

  logic [31:0] w_bin;

  assign w_bin = 32'(i_bin);
  assign o_err = (w_bin >= 32'(ONE_HOT));

  for (genvar g = 0; g < ONE_HOT; g++) begin : g_bit
    assign o_word[g] = decode_bit(w_bin, 32'(g), 32'(ONE_HOT), i_mode);
  end

endmodule

// File: rtl/binary_one_hot_stream.sv
// Registered valid/ready binary-to-one-hot decoder with a 2-entry skid buffer and a saturating error counter.
// Optional feature macro: BIN_OH_THERMO_EN adds the Mode_I port and thermometer decode.
module binary_one_hot_stream
  import binary_one_hot_pkg::*;
#(
  parameter int BINARY    = 4,
  parameter int ONE_HOT   = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 Clk_I,
  input  logic                 Rst_I,
  input  logic                 Valid_I,
  output logic                 Ready_O,
  input  logic [BINARY-1:0]    Bin_I,
`ifdef BIN_OH_THERMO_EN
  input  logic                 Mode_I,
`endif
  output logic                 Valid_O,
  input  logic                 Ready_I,
  output logic [ONE_HOT-1:0]   One_Hot_O,
  output logic                 Err_O,
  input  logic                 Clr_Err_I,
  output logic [ERR_CNT_W-1:0] Err_Cnt_O
);

  if (ONE_HOT < 2 || ONE_HOT > (1 << BINARY)) begin : g_bad_cfg
    $error("binary_one_hot_stream: ONE_HOT must satisfy 2 <= ONE_HOT <= 2**BINARY");
  end

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  skid_state_t          r_state, w_state_nxt;
  logic                 r_ready;
  logic [ONE_HOT-1:0]   r_main_word, r_skid_word;
  logic                 r_main_err, r_skid_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_mode, w_dec_err, w_accept, w_xfer, w_valid;
  logic                 w_load_main, w_load_skid, w_skid_to_main;
  logic [ONE_HOT-1:0]   w_dec_word;

`ifdef BIN_OH_THERMO_EN
  assign w_mode = Mode_I;
`else
  assign w_mode = MODE_ONE_HOT;
`endif

  binary_one_hot_dec #(
    .BINARY  (BINARY),
    .ONE_HOT (ONE_HOT)
  ) u_dec (
    .i_bin  (Bin_I),
    .i_mode (w_mode),
    .o_word (w_dec_word),
    .o_err  (w_dec_err)
  );

  // Both handshakes are built from flops only, so neither ready nor valid
  // has a combinational path from the other side.
  assign w_valid  = (r_state != EMPTY);
  assign w_accept = Valid_I & r_ready;
  assign w_xfer   = w_valid & Ready_I;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ONE;
          w_load_main = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_xfer) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (w_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_xfer) begin
          w_state_nxt    = ONE;
          w_skid_to_main = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk_I or posedge Rst_I) begin
    if (Rst_I) begin
      r_state <= EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != FULL);
    end
  end

  // NOTE: the data registers are reset too, because One_Hot_O/Err_O must read zero during reset.
  always_ff @(posedge Clk_I or posedge Rst_I) begin
    if (Rst_I) begin
      r_main_word <= '0;
      r_main_err  <= 1'b0;
      r_skid_word <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_word <= w_dec_word;
        r_main_err  <= w_dec_err;
      end else if (w_skid_to_main) begin
        r_main_word <= r_skid_word;
        r_main_err  <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_word <= w_dec_word;
        r_skid_err  <= w_dec_err;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at its maximum.
  always_ff @(posedge Clk_I or posedge Rst_I) begin
    if (Rst_I) begin
      r_err_cnt <= '0;
    end else if (Clr_Err_I) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_dec_err && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign Ready_O   = r_ready;
  assign Valid_O   = w_valid;
  assign One_Hot_O = r_main_word;
  assign Err_O     = r_main_err;
  assign Err_Cnt_O = r_err_cnt;

endmodule

// File: tb/tb_binary_one_hot_stream.sv
// Directed self-checking bench: instance a is the default 4/16/8 build, instance b is a 4/12/2 build
// used for out-of-range, error-counter saturation and reset-while-full cases.
module tb_binary_one_hot_stream;

  logic clk = 1'b0;
  logic rst;

  logic        a_valid_i, a_ready_o, a_valid_o, a_ready_i, a_err_o, a_clr;
  logic [3:0]  a_bin;
  logic [15:0] a_oh;
  logic [7:0]  a_cnt;

  logic        b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_err_o, b_clr;
  logic [3:0]  b_bin;
  logic [11:0] b_oh;
  logic [1:0]  b_cnt;

`ifdef BIN_OH_THERMO_EN
  logic a_mode, b_mode;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  binary_one_hot_stream #(.BINARY(4), .ONE_HOT(16), .ERR_CNT_W(8)) u_dut_a (
    .Clk_I     (clk),
    .Rst_I     (rst),
    .Valid_I   (a_valid_i),
    .Ready_O   (a_ready_o),
    .Bin_I     (a_bin),
`ifdef BIN_OH_THERMO_EN
    .Mode_I    (a_mode),
`endif
    .Valid_O   (a_valid_o),
    .Ready_I   (a_ready_i),
    .One_Hot_O (a_oh),
    .Err_O     (a_err_o),
    .Clr_Err_I (a_clr),
    .Err_Cnt_O (a_cnt)
  );

  binary_one_hot_stream #(.BINARY(4), .ONE_HOT(12), .ERR_CNT_W(2)) u_dut_b (
    .Clk_I     (clk),
    .Rst_I     (rst),
    .Valid_I   (b_valid_i),
    .Ready_O   (b_ready_o),
    .Bin_I     (b_bin),
`ifdef BIN_OH_THERMO_EN
    .Mode_I    (b_mode),
`endif
    .Valid_O   (b_valid_o),
    .Ready_I   (b_ready_i),
    .One_Hot_O (b_oh),
    .Err_O     (b_err_o),
    .Clr_Err_I (b_clr),
    .Err_Cnt_O (b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_oh;
    logic [1:0]  exp_cnt;
    logic [3:0]  oor_codes [5];

    rst = 1'b1;
    a_valid_i = 1'b1; a_bin = 4'd5; a_ready_i = 1'b1; a_clr = 1'b0;
    b_valid_i = 1'b1; b_bin = 4'd1; b_ready_i = 1'b1; b_clr = 1'b0;
`ifdef BIN_OH_THERMO_EN
    a_mode = 1'b0; b_mode = 1'b0;
`endif

    // Reset state with Valid_I high (must be ignored).
    step(); step();
    check("rst_ready",   32'(a_ready_o), 32'd1);
    check("rst_valid",   32'(a_valid_o), 32'd0);
    check("rst_oh",      32'(a_oh),      32'd0);
    check("rst_err",     32'(a_err_o),   32'd0);
    check("rst_cnt",     32'(a_cnt),     32'd0);
    check("rst_b_valid", 32'(b_valid_o), 32'd0);

    a_valid_i = 1'b0; b_valid_i = 1'b0;
    rst = 1'b0;
    step();

    // Single beat, one-cycle latency.
    a_valid_i = 1'b1; a_bin = 4'd5;
    step();
    a_valid_i = 1'b0;
    check("lat_valid", 32'(a_valid_o), 32'd1);
    check("lat_oh",    32'(a_oh),      32'h0020);
    check("lat_err",   32'(a_err_o),   32'd0);
    step();
    check("lat_drain", 32'(a_valid_o), 32'd0);

    // Backpressure: 3 and 7 accepted, 9 stalled, then released in order.
    a_ready_i = 1'b0;
    a_valid_i = 1'b1; a_bin = 4'd3;
    step();
    check("bp_ready_one", 32'(a_ready_o), 32'd1);
    a_bin = 4'd7;
    step();
    check("bp_ready_full", 32'(a_ready_o), 32'd0);
    check("bp_oh_hold0",   32'(a_oh),      32'h0008);
    a_bin = 4'd9;
    step();
    check("bp_oh_hold1",   32'(a_oh),      32'h0008);
    check("bp_valid_hold", 32'(a_valid_o), 32'd1);
    check("bp_ready_hold", 32'(a_ready_o), 32'd0);
    a_ready_i = 1'b1;
    step();
    check("bp_out_7",       32'(a_oh),      32'h0080);
    check("bp_ready_again", 32'(a_ready_o), 32'd1);
    step();
    a_valid_i = 1'b0;
    check("bp_out_9",  32'(a_oh),      32'h0200);
    check("bp_v_9",    32'(a_valid_o), 32'd1);
    step();
    check("bp_empty",  32'(a_valid_o), 32'd0);

    // Back-to-back walking one-hot at full throughput.
    for (int i = 0; i < 16; i++) begin
      a_valid_i = 1'b1; a_bin = 4'(i);
      step();
      exp_oh = 16'h0001 << i;
      check($sformatf("walk_v%0d", i),  32'(a_valid_o), 32'd1);
      check($sformatf("walk_oh%0d", i), 32'(a_oh),      32'(exp_oh));
      check($sformatf("walk_r%0d", i),  32'(a_ready_o), 32'd1);
    end
    a_valid_i = 1'b0;
    step();
    check("walk_end", 32'(a_valid_o), 32'd0);

`ifdef BIN_OH_THERMO_EN
    a_mode = 1'b1;
    a_valid_i = 1'b1; a_bin = 4'd3;
    step();
    check("thermo_3", 32'(a_oh), 32'h000F);
    a_bin = 4'd15;
    step();
    check("thermo_15", 32'(a_oh), 32'hFFFF);
    a_valid_i = 1'b0; a_mode = 1'b0;
    step();
`endif

    // Out-of-range on the 12-wide instance.
    b_valid_i = 1'b1; b_bin = 4'd13;
    step();
    check("oor_oh",  32'(b_oh),    32'h000);
    check("oor_err", 32'(b_err_o), 32'd1);
    check("oor_cnt", 32'(b_cnt),   32'd1);
    b_bin = 4'd14; b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    check("clr_prio",  32'(b_cnt),   32'd0);
    check("clr_err_o", 32'(b_err_o), 32'd1);
    b_bin = 4'd11;
    step();
    check("in_range_oh",  32'(b_oh),    32'h800);
    check("in_range_err", 32'(b_err_o), 32'd0);
    check("in_range_cnt", 32'(b_cnt),   32'd0);

    // Five out-of-range beats saturate a 2-bit counter at 3.
    oor_codes = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd12};
    exp_cnt = 2'd0;
    for (int i = 0; i < 5; i++) begin
      b_bin = oor_codes[i];
      step();
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      check($sformatf("sat_cnt%0d", i), 32'(b_cnt), 32'(exp_cnt));
    end
    b_valid_i = 1'b0;
    step();
    check("sat_hold", 32'(b_cnt), 32'd3);

    // Fill the buffer, then reset while FULL.
    b_ready_i = 1'b0;
    b_valid_i = 1'b1; b_bin = 4'd1;
    step();
    b_bin = 4'd2;
    step();
    check("full_ready", 32'(b_ready_o), 32'd0);
    check("full_valid", 32'(b_valid_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rstfull_valid", 32'(b_valid_o), 32'd0);
    check("rstfull_ready", 32'(b_ready_o), 32'd1);
    check("rstfull_oh",    32'(b_oh),      32'd0);
    check("rstfull_cnt",   32'(b_cnt),     32'd0);
    step();
    check("rst_ignores_valid", 32'(b_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_one_hot_stream.md
# binary_one_hot_stream

Registered, flow-controlled binary-to-one-hot decoder for the encoder library. Accepts binary codes on a valid/ready input stream and emits one-hot (optionally thermometer) words on a valid/ready output stream, with one cycle of latency and full throughput. A 2-entry skid buffer provides the backpressure path. Out-of-range codes are flagged per beat and counted for diagnostics.

## Interface
- BINARY, 4, width of binary code
- ONE_HOT, 16, width of decoded word; elaboration error unless 2 ≤ ONE_HOT ≤ 2**BINARY
- ERR_CNT_W, 8, width of saturating error counter

- Clk_I  in  1  single clock, rising edge
- Rst_I  in  1  reset, asynchronous, active-high
- Valid_I  in  1  input beat valid
- Ready_O  out  1  block can accept a beat
- Bin_I  in  BINARY  binary code
- Mode_I  in  1  0 = one-hot, 1 = thermometer (present only with BIN_OH_THERMO_EN)
- Valid_O  out  1  output beat valid
- Ready_I  in  1  downstream accepts beat
- One_Hot_O  out  ONE_HOT  decoded word
- Err_O  out  1  current output beat came from an out-of-range code
- Clr_Err_I  in  1  synchronous clear of Err_Cnt_O
- Err_Cnt_O  out  ERR_CNT_W  count of accepted out-of-range beats, saturating

## Operation
- Input handshake: beat accepted when Valid_I && Ready_O. Output transfer: Valid_O && Ready_I.
- Decode of an accepted beat: Bin_I < ONE_HOT → bit Bin_I set, all others 0; Err=0. Bin_I ≥ ONE_HOT → word all zeros, Err=1.
- Thermometer mode: bits [Bin_I:0] set (Bin_I+1 ones); out-of-range behaves as above (zeros, Err=1). Mode_I is sampled with each accepted beat.
- Decoded word and Err travel together through the buffer; they are never split across beats.
- Skid buffer FSM, states EMPTY, ONE, FULL:
  - EMPTY: accept → ONE.
  - ONE: accept with transfer → ONE (main reg reloads); accept without transfer → FULL (beat into skid reg); transfer without accept → EMPTY.
  - FULL: no accept possible; transfer → ONE (skid reg moves to main reg).
- Ready_O is a flop: high in EMPTY/ONE, low in FULL. Valid_O is high in ONE/FULL.
- While Valid_O && !Ready_I, One_Hot_O and Err_O hold stable.
- Error counter: +1 on each accepted out-of-range beat. Holds at 2**ERR_CNT_W−1. Clr_Err_I has priority: a clear in the same cycle as an increment gives 0.

## Timing
- Reset values while Rst_I is high: state EMPTY, Ready_O=1, Valid_O=0, One_Hot_O=0, Err_O=0, Err_Cnt_O=0. Valid_I is ignored.
- Reset asserted mid-operation discards both buffered beats immediately; there is no drain.
- Latency: a beat accepted at edge N appears on Valid_O/One_Hot_O after edge N, so it is visible in cycle N+1.
- Throughput: 1 beat/cycle while Ready_I=1. Ready_O falls one cycle after the first stalled accept.
- Valid_O never depends combinationally on Ready_I; Ready_O never depends combinationally on Valid_I or Ready_I.

## Configuration
- BIN_OH_THERMO_EN defined: Mode_I port exists, and thermometer decode is available.
- Not defined: Mode_I port is absent, and decode is one-hot only. All other behaviour is identical.

## Structure
- Package binary_one_hot_pkg contains:
  - the skid-state enum typedef (EMPTY, ONE, FULL)
  - a parametrised decode function
  - the MODE_ONE_HOT/MODE_THERMO constants
- Sub-module binary_one_hot_dec: purely combinational decode of Bin_I/Mode_I to word plus Err. The top holds the FSM, registers and counter.

## Test plan
- Reset then Bin_I=5 with Ready_I=1 → next cycle Valid_O=1, One_Hot_O=16'h0020, Err_O=0.
- ONE_HOT=12, Bin_I=13 → One_Hot_O=12'h000, Err_O=1, Err_Cnt_O=1. Clr_Err_I together with a further Bin_I=14 → Err_Cnt_O=0.
- Ready_I=0 while beats 3, 7, 9 are offered → 3 and 7 are accepted, Ready_O=0, and 9 is stalled. Ready_I=1 → outputs 16'h0008, then 16'h0080, then 16'h0200, in order, with no loss or duplication.
- Back-to-back stream 0..15 with Ready_I=1 → 16 consecutive output beats, one-hot walking from bit 0 to bit 15.
- With BIN_OH_THERMO_EN, Mode_I=1 and Bin_I=3 → One_Hot_O=16'h000F. Bin_I=15 → 16'hFFFF.
- ERR_CNT_W=2 with 5 out-of-range beats → Err_Cnt_O saturates at 3. Rst_I asserted while in FULL → Valid_O=0 and Ready_O=1 immediately.
